// File: rtl/rv_pkg.sv
// Shared writeback definitions: default datapath geometry, the x0 register
// index and the writeback request record used by pipeline-side code.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_ctrl_if.sv
// Bus bundle between the pipeline and the writeback controller: the ALU and
// load writeback handshakes, the register file write/read side, the operand
// outputs and the load scoreboard signals (live only with
// RV_WB_SCOREBOARD_EN).
interface reg_wb_ctrl_if #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5
);

    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [WIDTH-1:0]      alu_data;
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_WIDTH-1:0] ld_rd;
    logic [WIDTH-1:0]      ld_data;
    logic                  we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [WIDTH-1:0]      w_data;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [ADDR_WIDTH-1:0] r_addr2;
    logic [WIDTH-1:0]      read_reg1;
    logic [WIDTH-1:0]      read_reg2;
    logic [WIDTH-1:0]      op1;
    logic [WIDTH-1:0]      op2;
    logic                  ld_issue;
    logic [ADDR_WIDTH-1:0] ld_issue_rd;
    logic                  busy1;
    logic                  busy2;

    // Writeback controller side.
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  r_addr1, r_addr2, read_reg1, read_reg2,
        input  ld_issue, ld_issue_rd,
        output alu_ready, ld_ready,
        output we, w_addr, w_data,
        output op1, op2, busy1, busy2
    );

    // Pipeline / register file side.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output r_addr1, r_addr2, read_reg1, read_reg2,
        output ld_issue, ld_issue_rd,
        input  alu_ready, ld_ready,
        input  we, w_addr, w_data,
        input  op1, op2, busy1, busy2
    );

endinterface

// File: rtl/reg_wb_ctrl_wb_arbiter.sv
// Writeback arbiter: loads win by default; after MAX_DEFER consecutive ALU
// losses the ALU is guaranteed one win. Ready outputs are combinational from
// the valids and the defer count.
module wb_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned MAX_DEFER  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid_i,
    input  logic [ADDR_WIDTH-1:0] alu_rd_i,
    input  logic [WIDTH-1:0]      alu_data_i,
    input  logic                  ld_valid_i,
    input  logic [ADDR_WIDTH-1:0] ld_rd_i,
    input  logic [WIDTH-1:0]      ld_data_i,
    output logic                  alu_ready_o,
    output logic                  ld_ready_o,
    output logic                  ld_acc_o,
    output logic                  sel_valid_o,
    output logic [ADDR_WIDTH-1:0] sel_rd_o,
    output logic [WIDTH-1:0]      sel_data_o
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_DEFER);

    logic [3:0] defer_q, defer_d;
    logic       forced;
    logic       alu_acc;
    logic       ld_acc;

    // Priority selection; at most one source is accepted per cycle.
    always_comb begin
        forced      = (defer_q == MAX_CNT);
        alu_ready_o = forced ? 1'b1 : ~ld_valid_i;
        ld_ready_o  = forced ? ~alu_valid_i : 1'b1;
        alu_acc     = alu_valid_i & alu_ready_o;
        ld_acc      = ld_valid_i & ld_ready_o;
        ld_acc_o    = ld_acc;
        sel_valid_o = alu_acc | ld_acc;
        sel_rd_o    = ld_acc ? ld_rd_i   : alu_rd_i;
        sel_data_o  = ld_acc ? ld_data_i : alu_data_i;
    end

    // Count consecutive ALU losses, saturating at MAX_DEFER.
    always_comb begin
        defer_d = defer_q;
        if (!alu_valid_i || alu_acc) begin
            defer_d = '0;
        end else if (ld_valid_i && (defer_q < MAX_CNT)) begin
            defer_d = defer_q + 4'd1;
        end
    end

    // Defer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            defer_q <= '0;
        end else begin
            defer_q <= defer_d;
        end
    end

endmodule

// File: rtl/reg_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load results onto the registered
// register file write port and corrects same-edge read-after-write reads.
// Optional load scoreboard enabled by defining RV_WB_SCOREBOARD_EN.
module reg_wb_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned WIDTH      = XLEN,
    parameter int unsigned ADDR_WIDTH = REG_ADDR_W,
    parameter int unsigned MAX_DEFER  = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_wb_ctrl_if.slave  bus
);

    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);

    logic                  alu_ready;
    logic                  ld_ready;
    logic                  ld_acc;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [WIDTH-1:0]      sel_data;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [WIDTH-1:0]      w_data_q, w_data_d;
    logic                  hit1_q, hit1_d;
    logic                  hit2_q, hit2_d;
    logic [WIDTH-1:0]      byp_q;

    wb_arbiter #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MAX_DEFER  (MAX_DEFER)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid_i (bus.alu_valid),
        .alu_rd_i    (bus.alu_rd),
        .alu_data_i  (bus.alu_data),
        .ld_valid_i  (bus.ld_valid),
        .ld_rd_i     (bus.ld_rd),
        .ld_data_i   (bus.ld_data),
        .alu_ready_o (alu_ready),
        .ld_ready_o  (ld_ready),
        .ld_acc_o    (ld_acc),
        .sel_valid_o (sel_valid),
        .sel_rd_o    (sel_rd),
        .sel_data_o  (sel_data)
    );

    // Write stage next state: x0 writes are accepted but never presented.
    always_comb begin
        we_d     = sel_valid & (sel_rd != ZERO);
        w_addr_d = we_d ? sel_rd   : w_addr_q;
        w_data_d = we_d ? sel_data : w_data_q;
    end

    // Bypass hit detection against the write being committed this edge.
    always_comb begin
        hit1_d = we_q & (w_addr_q == bus.r_addr1) & (w_addr_q != ZERO);
        hit2_d = we_q & (w_addr_q == bus.r_addr2) & (w_addr_q != ZERO);
    end

    // Write port and bypass registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            hit1_q   <= 1'b0;
            hit2_q   <= 1'b0;
            byp_q    <= '0;
        end else begin
            we_q     <= we_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            hit1_q   <= hit1_d;
            hit2_q   <= hit2_d;
            byp_q    <= w_data_q;
        end
    end

    assign bus.alu_ready = alu_ready;
    assign bus.ld_ready  = ld_ready;
    assign bus.we        = we_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.w_data    = w_data_q;
    assign bus.op1       = hit1_q ? byp_q : bus.read_reg1;
    assign bus.op2       = hit2_q ? byp_q : bus.read_reg2;

`ifdef RV_WB_SCOREBOARD_EN
    localparam int unsigned NREGS = 1 << ADDR_WIDTH;

    logic [NREGS-1:0] busy_q, busy_d;

    // Clear on load writeback, then set on issue so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (ld_acc) begin
            busy_d[bus.ld_rd] = 1'b0;
        end
        if (bus.ld_issue && (bus.ld_issue_rd != ZERO)) begin
            busy_d[bus.ld_issue_rd] = 1'b1;
        end
    end

    // Busy-bit storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.busy1 = busy_q[bus.r_addr1];
    assign bus.busy2 = busy_q[bus.r_addr2];
`else
    logic unused_sb;

    assign unused_sb = ^{bus.ld_issue, bus.ld_issue_rd, ld_acc};
    assign bus.busy1 = 1'b0;
    assign bus.busy2 = 1'b0;
`endif

endmodule
